uart_byte_rx: RTL and testbench

//  Receives 8N1 asynchronous serial bytes from the FT2232H UART line (FT2232H_TX pin) and presents

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_rx_bit_sync.sv | 25 ++
 rtl/uart_byte_rx.sv | 149 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the byte receiver and the companion transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Clock cycles per bit period, rounded to the nearest integer.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_rx_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input bit, with a configurable reset level.
module bit_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; reset presets every stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: synchroniser, 3-sample mid-bit majority vote, framing/overrun
// detection and a one-deep valid/ready holding register.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK12M,
    input  logic       RESET_N,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_FRAME_ERR,
    output logic       RX_OVERRUN,
    output logic       RX_BUSY
);

    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CW  = $clog2(CPB);
    localparam logic [CW-1:0] MID_C  = CW'(CPB / 2 + 1);
    localparam logic [CW-1:0] LAST_C = CW'(CPB - 1);

    logic            rxs;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [3:0]      bidx_q, bidx_d;
    logic [2:0]      maj_q, maj_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            vote;
    logic            at_mid;
    logic            at_wrap;
    logic            byte_done;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i  (CLK12M),
        .rst_ni (RESET_N),
        .d_i    (RXD),
        .q_o    (rxs)
    );

    assign vote    = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
    assign at_mid  = (bcnt_q == MID_C);
    assign at_wrap = (bcnt_q == LAST_C);

    // Next-state logic for the frame FSM, bit timing, data shifter and holding register.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = at_wrap ? '0 : bcnt_q + CW'(1);
        bidx_d    = bidx_q;
        maj_d     = {maj_q[1:0], rxs};
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (at_mid && vote) begin
                    state_d = IDLE;
                end else if (at_wrap) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
            end
            DATA: begin
                if (at_mid) begin
                    shreg_d = {vote, shreg_q[7:1]};
                    bidx_d  = bidx_q + 4'd1;
                end
                if (at_wrap && bidx_q == 4'd8) state_d = STOP;
            end
            STOP: begin
                if (at_mid) begin
                    if (vote) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                bcnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A consume and a new byte in the same cycle leave valid set with the new byte.
        if (valid_q && RX_READY) valid_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || RX_READY) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any frame in flight without pulses.
    always_ff @(posedge CLK12M) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            maj_q   <= '1;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            maj_q   <= maj_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_DATA      = data_q;
    assign RX_VALID     = valid_q;
    assign RX_FRAME_ERR = ferr_q;
    assign RX_OVERRUN   = ovr_q;
    assign RX_BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised bench for uart_byte_rx. The line rate is raised to 500 kBd so the 256-byte
// drift run stays short; glitch width is scaled to the same quarter-bit ratio.
module tb_uart_byte_rx;

    localparam int unsigned CLK_HZ  = 12000000;
    localparam int unsigned BAUD    = 500000;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned CPB     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned EXP_LAT = SYNC + 9 * CPB + CPB / 2 + 2;
    localparam real         BIT_NS  = 1.0e9 / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rdy_fix = 1'b0;
    logic       rdy_rand_en = 1'b0;
    logic       rnd_rdy = 1'b0;
    logic       rdy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    assign rdy = rdy_rand_en ? rnd_rdy : rdy_fix;

    uart_byte_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK12M       (clk),
        .RESET_N      (rst_n),
        .RXD          (rxd),
        .RX_DATA      (rx_data),
        .RX_VALID     (rx_valid),
        .RX_READY     (rdy),
        .RX_FRAME_ERR (ferr),
        .RX_OVERRUN   (ovr),
        .RX_BUSY      (busy)
    );

    always #41.667ns clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1ns;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    // Observation: accepted bytes, pulse counts, handshake invariants.
    logic [7:0] acc[$];
    int n_vrise = 0, n_vhigh = 0, n_ferr = 0, n_ovr = 0, n_both = 0, n_unstable = 0;
    int lat_last = 0;
    int fall_cyc = 0;
    logic vprev = 1'b0, rprev = 1'b0;
    logic [7:0] dprev = 8'h00;

    always @(negedge clk) begin
        if (rx_valid && rdy) acc.push_back(rx_data);
        if (rx_valid && !vprev) begin
            n_vrise++;
            lat_last = cyc - fall_cyc;
        end
        if (rx_valid) n_vhigh++;
        if (ferr) n_ferr++;
        if (ovr) n_ovr++;
        if (ferr && ovr) n_both++;
        if (vprev && !rprev && rx_valid && rx_data != dprev) n_unstable++;
        vprev = rx_valid;
        rprev = rdy;
        dprev = rx_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1ns;
    endtask

    // Drive one 8N1 frame, LSB first, with the given bit period and stop level.
    task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            #(bit_ns * 1.0ns);
        end
    endtask

    int base, f0, o0, v0, h0;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [31:0] obs;

    initial begin
        // Reset state
        rst_n = 1'b0;
        wait_cycles(5);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_cycles(10);

        // 1: single byte with consumer ready
        rdy_fix = 1'b1;
        base = acc.size(); f0 = n_ferr; o0 = n_ovr; v0 = n_vrise; h0 = n_vhigh;
        #13ns;
        send_byte(8'hA5, BIT_NS, 1'b1);
        wait_cycles(20);
        chk("t1_count", 32'(acc.size() - base), 32'd1);
        chk("t1_data", 32'(acc[base]), 32'hA5);
        chk("t1_valid_cycles", 32'(n_vhigh - h0), 32'd1);
        chk("t1_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t1_ovr", 32'(n_ovr - o0), 32'd0);
        chk("t1_latency_window", 32'(lat_last >= int'(EXP_LAT) - 1 && lat_last <= int'(EXP_LAT) + 1), 32'd1);

        // 2: quarter-bit low glitch on idle line
        f0 = n_ferr; v0 = n_vrise;
        rxd = 1'b0;
        wait_cycles(CPB / 4);
        chk("t2_busy_in_glitch", 32'(busy), 32'd1);
        rxd = 1'b1;
        wait_cycles(3 * CPB);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_valid", 32'(n_vrise - v0), 32'd0);
        chk("t2_ferr", 32'(n_ferr - f0), 32'd0);

        // 3: bad stop bit, line held low, then recovery
        f0 = n_ferr; v0 = n_vrise; base = acc.size();
        send_byte(8'h3C, BIT_NS, 1'b0);
        #200us;
        chk("t3_ferr_once", 32'(n_ferr - f0), 32'd1);
        chk("t3_no_valid", 32'(n_vrise - v0), 32'd0);
        chk("t3_busy_break", 32'(busy), 32'd1);
        rxd = 1'b1;
        wait_cycles(10);
        chk("t3_busy_release", 32'(busy), 32'd0);
        send_byte(8'h01, BIT_NS, 1'b1);
        wait_cycles(20);
        chk("t3_count", 32'(acc.size() - base), 32'd1);
        chk("t3_data", 32'(acc[acc.size() - 1]), 32'h01);

        // 4: back-to-back bytes with no consumer -> overrun, old byte kept
        rdy_fix = 1'b0;
        f0 = n_ferr; o0 = n_ovr; v0 = n_vrise; base = acc.size();
        send_byte(8'h55, BIT_NS, 1'b1);
        send_byte(8'hAA, BIT_NS, 1'b1);
        wait_cycles(20);
        chk("t4_valid_held", 32'(rx_valid), 32'd1);
        chk("t4_data", 32'(rx_data), 32'h55);
        chk("t4_ovr_once", 32'(n_ovr - o0), 32'd1);
        chk("t4_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t4_vrise", 32'(n_vrise - v0), 32'd1);
        rdy_fix = 1'b1;
        wait_cycles(1);
        rdy_fix = 1'b0;
        chk("t4_valid_drop", 32'(rx_valid), 32'd0);
        chk("t4_count", 32'(acc.size() - base), 32'd1);
        chk("t4_accepted", 32'(acc[acc.size() - 1]), 32'h55);

        // 5: reset mid-frame, then a clean byte
        rdy_fix = 1'b1;
        f0 = n_ferr; o0 = n_ovr; base = acc.size();
        rxd = 1'b0;
        #(BIT_NS * 1.0ns);
        rxd = 1'b1;
        #(BIT_NS * 3.3 * 1.0ns);
        wait_cycles(1);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        chk("t5_busy_reset", 32'(busy), 32'd0);
        chk("t5_valid_reset", 32'(rx_valid), 32'd0);
        wait_cycles(8 * CPB);
        send_byte(8'h12, BIT_NS, 1'b1);
        wait_cycles(20);
        chk("t5_count", 32'(acc.size() - base), 32'd1);
        chk("t5_data", 32'(acc[acc.size() - 1]), 32'h12);
        chk("t5_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t5_ovr", 32'(n_ovr - o0), 32'd0);

        // 6: random bytes at +2% then -2% baud with random back-pressure
        rdy_rand_en = 1'b1;
        f0 = n_ferr; o0 = n_ovr; base = acc.size();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, (i < 128) ? BIT_NS / 1.02 : BIT_NS / 0.98, 1'b1);
            #($urandom_range(0, 300) * 1.0ns);
        end
        wait_cycles(2 * CPB);
        rdy_rand_en = 1'b0;
        rdy_fix = 1'b1;
        wait_cycles(10);
        chk("t6_count", 32'(acc.size() - base), 32'd256);
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (base + i < acc.size()) ? 32'(acc[base + i]) : 32'hFFFF_FFFF;
            chk($sformatf("t6_byte%0d", i), obs, 32'(exp_q[i]));
        end
        chk("t6_ferr", 32'(n_ferr - f0), 32'd0);
        chk("t6_ovr", 32'(n_ovr - o0), 32'd0);

        chk("ferr_ovr_same_cycle", 32'(n_both), 32'd0);
        chk("data_stable_while_stalled", 32'(n_unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
